demux1_2_hs: RTL and testbench
==============================

Name: demux1_2_hs

Overview:
- Registered 1-to-2 demultiplexer; the inverse of the team's 2:1 data mux.
- Steers one input word stream to one of two output channels, selected either by an explicit `sel` or by an internal round-robin pointer.
- Each output channel has a one-deep holding register with valid/ready handshake and a delivered-word counter.
- Sits downstream of a mux or serial link, splitting an interleaved stream back into two channels.

Parameters:
- DW, 2, data word width.
- CNT_W, 8, width of per-channel delivered-word counters.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  synchronous reset, active low.
- in_data  in  DW  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts in_data this cycle.
- sel  in  1  explicit channel select (0 = out1, 1 = out2); used when rr_en = 0.
- rr_en  in  1  1 = round-robin steering, sel ignored.
- out1  out  DW  channel 1 data.
- out1_valid  out  1  channel 1 holds an undelivered word.
- out1_ready  in  1  channel 1 sink accepts.
- out2  out  DW  channel 2 data.
- out2_valid  out  1  channel 2 holds an undelivered word.
- out2_ready  in  1  channel 2 sink accepts.
- cnt1  out  CNT_W  words delivered on channel 1 (accepted by the sink).
- cnt2  out  CNT_W  words delivered on channel 2.
- rr_ptr  out  1  current round-robin target.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous, active-low on sys_rst_n.
- Reset values: out1, out2, out1_valid, out2_valid, cnt1, cnt2 and rr_ptr are all 0. Reset mid-operation discards held words; they are not delivered and not counted.
- Target: tgt = rr_en ? rr_ptr : sel.
- in_ready (combinational): !outT_valid || outT_ready, where T = tgt. Depends only on the target channel's state.
- Accept: in_valid && in_ready. On the next edge:
  - outT <= in_data and outT_valid <= 1.
  - If rr_en = 1, rr_ptr toggles.
- Latency: 1 cycle from accept to outT_valid.
- Drain: when outX_valid && outX_ready, cntX increments modulo 2^CNT_W (255 -> 0). outX_valid clears unless the same channel is loaded on that edge.
- Simultaneous drain and load on the same channel: the new word replaces the old one, valid stays 1, and the count increments once for the drained word. This gives full throughput of one word per cycle per channel.
- The non-target channel is unaffected by input activity and may drain independently in the same cycle.
- outX holds its last value when valid = 0; it is not cleared. Sinks must ignore outX while valid = 0.
- rr_ptr changes only on accept with rr_en = 1. It holds while rr_en = 0. When rr_en is re-enabled, steering resumes from the held pointer.
- A sel or rr_en change takes effect in the same cycle (combinational tgt). Upstream must hold sel stable while in_valid = 1 and in_ready = 0.
- Backpressure: a stalled target channel deasserts in_ready, even if the other channel is free. There is no reordering and no skipping of a stalled channel in round-robin mode.
- Valid stability: outX_valid never drops without a handshake. outX does not change while outX_valid = 1 and outX_ready = 0.

Decomposition:
- Shared package demux_pkg holds:
  - constants CH1 = 1'b0 and CH2 = 1'b1;
  - defaults DW_DEF = 2 and CNT_W_DEF = 8.
- Sub-module demux_ch_buf (one-deep register, valid flag, delivered counter), instantiated twice.
- The top level holds target selection, in_ready generation and rr_ptr.

Test Plan:
1. Reset with in_valid = 1 and sel = 1 held -> all outputs 0 throughout reset. The first accept lands the cycle after sys_rst_n rises.
2. rr_en = 0, both readys = 1, sel = 0, in_data = 2'b10 -> out1 = 2'b10 and out1_valid = 1 one cycle later. cnt1 = 1 after the drain; channel 2 is untouched.
3. rr_en = 1, readys = 1, stream 2'b00, 2'b01, 2'b10, 2'b11 on consecutive cycles -> out1 receives 00 then 10, out2 receives 01 then 11. cnt1 = cnt2 = 2 and rr_ptr = 0 at the end.
4. sel = 1, out2_ready = 0, two words offered -> first word held on out2 and in_ready = 0. Raising out2_ready delivers the first word, accepts the second in the same cycle, and cnt2 becomes 1 then 2.
5. out1 stalled, sel switched to 1 with out2 ready -> in_ready = 1, words flow to out2, and out1 keeps its held value with valid = 1.
6. 256 words drained on channel 1 -> cnt1 wraps to 0. Asserting reset mid-stream with out2_valid = 1 clears valid and counters; the held word is not delivered.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 handshake demultiplexer.
package demux_pkg;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    localparam int unsigned DW_DEF    = 2;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/demux1_2_hs_if.sv
// Input stream, two output channels and status of the 1-to-2 demultiplexer.
interface demux1_2_hs_if
    import demux_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic             rr_en;
    logic [DW-1:0]    out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [DW-1:0]    out2;
    logic             out2_valid;
    logic             out2_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             rr_ptr;

    // master drives the input stream and sink readys; slave is the demultiplexer
    modport master (
        output in_data, in_valid, sel, rr_en, out1_ready, out2_ready,
        input  in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2, rr_ptr
    );

    modport slave (
        input  in_data, in_valid, sel, rr_en, out1_ready, out2_ready,
        output in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2, rr_ptr
    );

endinterface

// File: rtl/demux_ch_buf.sv
// One-deep output holding register with valid flag and delivered-word counter.
module demux_ch_buf
    import demux_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DW-1:0]    load_data,
    input  logic             ready,
    output logic [DW-1:0]    data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    logic [DW-1:0]    data_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drain;

    assign drain = valid_q && ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // A load on the draining edge replaces the word and keeps valid high.
            if (load) begin
                data_q  <= load_data;
                valid_q <= 1'b1;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
            if (drain) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux1_2_hs.sv
// Registered 1-to-2 demultiplexer: target selection, in_ready and round-robin pointer.
module demux1_2_hs
    import demux_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic          sys_clk,
    input logic          sys_rst_n,
    demux1_2_hs_if.slave bus
);

    logic             rr_ptr_q;
    logic             tgt;
    logic             accept;
    logic             load1;
    logic             load2;
    logic [DW-1:0]    out1_data;
    logic [DW-1:0]    out2_data;
    logic             out1_vld;
    logic             out2_vld;
    logic [CNT_W-1:0] cnt1_val;
    logic [CNT_W-1:0] cnt2_val;

    assign tgt = bus.rr_en ? rr_ptr_q : bus.sel;

    // Only the target channel gates acceptance; the other channel never unblocks a stall.
    assign bus.in_ready = (tgt == CH1) ? (!out1_vld || bus.out1_ready)
                                       : (!out2_vld || bus.out2_ready);

    assign accept = bus.in_valid && bus.in_ready;
    assign load1  = accept && (tgt == CH1);
    assign load2  = accept && (tgt == CH2);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rr_ptr_q <= CH1;
        end else if (accept && bus.rr_en) begin
            rr_ptr_q <= ~rr_ptr_q;
        end
    end

    demux_ch_buf #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_ch1 (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .load      (load1),
        .load_data (bus.in_data),
        .ready     (bus.out1_ready),
        .data      (out1_data),
        .valid     (out1_vld),
        .cnt       (cnt1_val)
    );

    demux_ch_buf #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_ch2 (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .load      (load2),
        .load_data (bus.in_data),
        .ready     (bus.out2_ready),
        .data      (out2_data),
        .valid     (out2_vld),
        .cnt       (cnt2_val)
    );

    assign bus.out1       = out1_data;
    assign bus.out1_valid = out1_vld;
    assign bus.out2       = out2_data;
    assign bus.out2_valid = out2_vld;
    assign bus.cnt1       = cnt1_val;
    assign bus.cnt2       = cnt2_val;
    assign bus.rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_demux1_2_hs.sv
// Scoreboard bench for demux1_2_hs: per-channel expected queues filled on accept, drained on delivery.
module tb_demux1_2_hs;
    import demux_pkg::*;

    localparam int unsigned DW    = 2;
    localparam int unsigned CNT_W = 8;

    logic sys_clk;
    logic sys_rst_n;

    demux1_2_hs_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    demux1_2_hs #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int unsigned vectors;
    int unsigned errors;

    logic [DW-1:0]    exp1_q[$];
    logic [DW-1:0]    exp2_q[$];
    logic [CNT_W-1:0] m_cnt1;
    logic [CNT_W-1:0] m_cnt2;
    logic             m_rr;
    logic             m_tgt;
    logic             m_rdy;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    // Mid-cycle model: what the coming rising edge will do.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            exp1_q.delete();
            exp2_q.delete();
            m_cnt1 = '0;
            m_cnt2 = '0;
            m_rr   = CH1;
        end else begin
            m_tgt = bus.rr_en ? m_rr : bus.sel;
            m_rdy = (m_tgt == CH1) ? (exp1_q.size() == 0 || bus.out1_ready)
                                   : (exp2_q.size() == 0 || bus.out2_ready);
            check("out1_valid", bus.out1_valid, exp1_q.size() != 0);
            check("out2_valid", bus.out2_valid, exp2_q.size() != 0);
            check("cnt1", bus.cnt1, m_cnt1);
            check("cnt2", bus.cnt2, m_cnt2);
            check("rr_ptr", bus.rr_ptr, m_rr);
            if (bus.in_valid) check("in_ready", bus.in_ready, m_rdy);
            if (bus.out1_valid && bus.out1_ready && exp1_q.size() != 0) begin
                check("out1_data", bus.out1, exp1_q.pop_front());
                m_cnt1 = m_cnt1 + 1'b1;
            end
            if (bus.out2_valid && bus.out2_ready && exp2_q.size() != 0) begin
                check("out2_data", bus.out2, exp2_q.pop_front());
                m_cnt2 = m_cnt2 + 1'b1;
            end
            if (bus.in_valid && m_rdy) begin
                if (m_tgt == CH1) exp1_q.push_back(bus.in_data);
                else              exp2_q.push_back(bus.in_data);
                if (bus.rr_en) m_rr = ~m_rr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors        = 0;
        errors         = 0;
        sys_rst_n      = 1'b0;
        bus.in_data    = 2'b01;
        bus.in_valid   = 1'b1;
        bus.sel        = 1'b1;
        bus.rr_en      = 1'b0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;

        // 1: reset with a word offered; nothing lands until reset is released
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out2_valid", bus.out2_valid, 1'b0);
            check("rst_out2", bus.out2, 2'b00);
            check("rst_out1_valid", bus.out1_valid, 1'b0);
            check("rst_out1", bus.out1, 2'b00);
            check("rst_cnt1", bus.cnt1, 8'd0);
            check("rst_cnt2", bus.cnt2, 8'd0);
            check("rst_rr_ptr", bus.rr_ptr, 1'b0);
        end
        sys_rst_n = 1'b1;
        #1;
        check("t1_pre_accept", bus.out2_valid, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("t1_out2_valid", bus.out2_valid, 1'b1);
        check("t1_out2", bus.out2, 2'b01);

        // 2: explicit select to channel 1, then drain
        do_reset();
        bus.rr_en      = 1'b0;
        bus.sel        = CH1;
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        bus.in_data    = 2'b10;
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t2_out1", bus.out1, 2'b10);
        check("t2_out1_valid", bus.out1_valid, 1'b1);
        tick();
        check("t2_cnt1", bus.cnt1, 8'd1);
        check("t2_out2_valid", bus.out2_valid, 1'b0);
        check("t2_cnt2", bus.cnt2, 8'd0);

        // 3: round-robin stream
        do_reset();
        bus.rr_en    = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = DW'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("t3_cnt1", bus.cnt1, 8'd2);
        check("t3_cnt2", bus.cnt2, 8'd2);
        check("t3_rr_ptr", bus.rr_ptr, 1'b0);
        check("t3_out1_last", bus.out1, 2'b10);
        check("t3_out2_last", bus.out2, 2'b11);

        // 4: stalled channel 2 backpressures, then drain and load on the same edge
        do_reset();
        bus.rr_en      = 1'b0;
        bus.sel        = CH2;
        bus.out2_ready = 1'b0;
        bus.out1_ready = 1'b1;
        bus.in_data    = 2'b01;
        bus.in_valid   = 1'b1;
        tick();
        bus.in_data = 2'b11;
        check("t4_in_ready_stall", bus.in_ready, 1'b0);
        tick();
        check("t4_out2_held", bus.out2, 2'b01);
        check("t4_in_ready_still", bus.in_ready, 1'b0);
        bus.out2_ready = 1'b1;
        #1;
        check("t4_in_ready_open", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("t4_cnt2_a", bus.cnt2, 8'd1);
        check("t4_out2_new", bus.out2, 2'b11);
        check("t4_out2_valid", bus.out2_valid, 1'b1);
        tick();
        check("t4_cnt2_b", bus.cnt2, 8'd2);

        // 5: channel 1 stalled, traffic switched to channel 2
        do_reset();
        bus.sel        = CH1;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b1;
        bus.in_data    = 2'b10;
        bus.in_valid   = 1'b1;
        tick();
        bus.sel = CH2;
        #1;
        check("t5_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.in_data = DW'(i + 1);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        check("t5_out1_held", bus.out1, 2'b10);
        check("t5_out1_valid", bus.out1_valid, 1'b1);
        check("t5_cnt2", bus.cnt2, 8'd3);

        // 6: counter wrap on channel 1, then reset discarding a held word
        do_reset();
        bus.sel        = CH1;
        bus.out1_ready = 1'b1;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.in_data = DW'(i);
            tick();
            if (i == 255) check("t6_cnt1_255", bus.cnt1, 8'd255);
        end
        bus.in_valid = 1'b0;
        tick();
        check("t6_cnt1_wrap", bus.cnt1, 8'd0);
        bus.sel        = CH2;
        bus.out2_ready = 1'b0;
        bus.in_data    = 2'b11;
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t6_out2_valid_held", bus.out2_valid, 1'b1);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        check("t6_rst_out2_valid", bus.out2_valid, 1'b0);
        check("t6_rst_cnt1", bus.cnt1, 8'd0);
        bus.out2_ready = 1'b1;
        tick();
        tick();
        check("t6_rst_cnt2", bus.cnt2, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
